// File: rtl/yuv_plane_seq_if.sv
// Control-bus and DMA handshake bundle for the YUV plane sequencer.
// slave: sequencer side (bus slave, DMA requester); master: CPU + DMA side.
interface yuv_plane_seq_if #(
    parameter int LEN_W = 24
);
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic             irq;
    logic             dma_start;
    logic             dma_ready;
    logic [31:0]      dma_addr;
    logic [LEN_W-1:0] dma_len;
    logic             dma_done;
    logic             dma_abort;
    logic [3:0]       yuv_ctrl;

    modport slave (
        input  address, chipselect, write_n, writedata,
        input  dma_ready, dma_done,
        output readdata, irq, dma_start, dma_addr, dma_len,
        output dma_abort, yuv_ctrl
    );

    modport master (
        output address, chipselect, write_n, writedata,
        output dma_ready, dma_done,
        input  readdata, irq, dma_start, dma_addr, dma_len,
        input  dma_abort, yuv_ctrl
    );
endinterface

// File: rtl/yuv_plane_seq.sv
// Moves one 4:2:0 frame as Y, U, V plane DMA transfers from a register-programmed size/base.
// Ports: clk, reset_n (sync, active-low), bus (register slave + DMA request/done + yuv_ctrl).
module yuv_plane_seq #(
    parameter int DIM_W = 12,
    parameter int LEN_W = 24
) (
    input  logic            clk,
    input  logic            reset_n,
    yuv_plane_seq_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       r_plane;
    logic             r_irq_en;
    logic             r_cont;
    logic             r_done;
    logic             r_err;
    logic             r_parity;
    logic             r_abort;
    logic [15:0]      r_frame_cnt;
    logic [DIM_W-1:0] r_fw;
    logic [DIM_W-1:0] r_fh;
    logic [31:0]      r_base;
    logic [DIM_W-1:0] r_sw;
    logic [DIM_W-1:0] r_sh;
    logic [31:0]      r_sbase;
    logic [LEN_W-1:0] r_ysize;
    logic [LEN_W-1:0] r_csize;

    logic               w_wr;
    logic               w_wr_ctrl;
    logic               w_wr_stat;
    logic               w_start;
    logic               w_abort;
    logic               w_busy;
    logic               w_err_set;
    logic               w_frame_end;
    logic [2*DIM_W-1:0] w_prod;
    logic [31:0]        w_y32;
    logic [31:0]        w_c32;
    logic [31:0]        w_addr;
    logic [LEN_W-1:0]   w_len;

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_wr_ctrl = w_wr & (bus.address == 3'd0);
    assign w_wr_stat = w_wr & (bus.address == 3'd1);
    // Abort in the same write suppresses start.
    assign w_abort   = w_wr_ctrl & bus.writedata[2];
    assign w_start   = w_wr_ctrl & bus.writedata[0] & ~bus.writedata[2];
    assign w_busy    = (r_state != S_IDLE);

    assign w_err_set = (r_state == S_IDLE) & w_start
                     & ((r_fw == '0) | (r_fh == '0));
    assign w_frame_end = (r_state == S_WAIT) & bus.dma_done
                       & (r_plane == 2'd2) & ~w_abort;

    assign w_prod = {{DIM_W{1'b0}}, r_sw} * {{DIM_W{1'b0}}, r_sh};
    assign w_y32  = 32'(r_ysize);
    assign w_c32  = 32'(r_csize);

    always_comb begin
        w_addr = '0;
        w_len  = '0;
        if (r_state == S_ISSUE) begin
            case (r_plane)
                2'd0: begin
                    w_addr = r_sbase;
                    w_len  = r_ysize;
                end
                2'd1: begin
                    w_addr = r_sbase + w_y32;
                    w_len  = r_csize;
                end
                default: begin
                    w_addr = r_sbase + w_y32 + w_c32;
                    w_len  = r_csize;
                end
            endcase
        end
    end

    assign bus.dma_start = (r_state == S_ISSUE);
    assign bus.dma_addr  = w_addr;
    assign bus.dma_len   = w_len;
    assign bus.dma_abort = r_abort;
    assign bus.irq       = r_done & r_irq_en;
    assign bus.yuv_ctrl  = {w_busy, r_parity, r_plane};

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0: bus.readdata = {28'd0, r_cont, 1'b0, r_irq_en, 1'b0};
            3'd1: bus.readdata = {r_frame_cnt, 11'd0, r_err, r_done,
                                  r_plane, w_busy};
            3'd2: bus.readdata[DIM_W-1:0] = r_fw;
            3'd3: bus.readdata[DIM_W-1:0] = r_fh;
            3'd4: bus.readdata = r_base;
            default: bus.readdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_plane     <= 2'd0;
            r_irq_en    <= 1'b0;
            r_cont      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_parity    <= 1'b0;
            r_abort     <= 1'b0;
            r_frame_cnt <= '0;
            r_fw        <= '0;
            r_fh        <= '0;
            r_base      <= '0;
            r_sw        <= '0;
            r_sh        <= '0;
            r_sbase     <= '0;
            r_ysize     <= '0;
            r_csize     <= '0;
        end else begin
            r_abort <= w_abort & w_busy;

            if (w_wr_ctrl) begin
                r_irq_en <= bus.writedata[1];
                r_cont   <= bus.writedata[3];
            end
            if (w_wr && bus.address == 3'd2) r_fw <= bus.writedata[DIM_W-1:0];
            if (w_wr && bus.address == 3'd3) r_fh <= bus.writedata[DIM_W-1:0];
            if (w_wr && bus.address == 3'd4) r_base <= bus.writedata;

            // Set events take priority over W1C clears.
            if (w_err_set)
                r_err <= 1'b1;
            else if (w_wr_stat && bus.writedata[4])
                r_err <= 1'b0;

            if (w_frame_end) begin
                r_done      <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_parity    <= ~r_parity;
            end else if (w_wr_stat && bus.writedata[3]) begin
                r_done <= 1'b0;
            end

            if (w_abort && w_busy) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start && !w_err_set) begin
                            r_sw    <= r_fw;
                            r_sh    <= r_fh;
                            r_sbase <= r_base;
                            r_state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_ysize <= LEN_W'(w_prod);
                        r_csize <= LEN_W'(w_prod >> 2);
                        r_plane <= 2'd0;
                        r_state <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (bus.dma_ready) r_state <= S_WAIT;
                    end
                    default: begin
                        if (bus.dma_done) begin
                            if (r_plane != 2'd2) begin
                                r_plane <= r_plane + 2'd1;
                                r_state <= S_ISSUE;
                            end else if (r_cont) begin
                                // Continuous mode picks up any new geometry.
                                r_sw    <= r_fw;
                                r_sh    <= r_fh;
                                r_sbase <= r_base;
                                r_state <= S_LOAD;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_yuv_plane_seq.sv
// Directed-vector bench for yuv_plane_seq.
// Scenarios: reset, single frame, backpressure, zero dim, abort, continuous, mid-op reset.
module tb_yuv_plane_seq;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    yuv_plane_seq_if #(.LEN_W(24)) bus();

    yuv_plane_seq #(.DIM_W(12), .LEN_W(24)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic accept_plane(input logic [31:0] ea, input logic [23:0] el,
                                input logic [1:0] ep, input int rdelay);
        int n;
        n = 0;
        while (!bus.dma_start && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.dma_start) begin
            errors++;
            $display("FAIL start_timeout: got 0 expected 1 (plane %0d)", ep);
            return;
        end
        checks++;
        if (bus.dma_addr !== ea || bus.dma_len !== el) begin
            errors++;
            $display("FAIL addr_len: got %h/%0d expected %h/%0d",
                     bus.dma_addr, bus.dma_len, ea, el);
        end
        checks++;
        if (bus.yuv_ctrl[1:0] !== ep || bus.yuv_ctrl[3] !== 1'b1) begin
            errors++;
            $display("FAIL yuv_ctrl: got %b expected plane %0d busy",
                     bus.yuv_ctrl, ep);
        end
        for (int i = 0; i < rdelay; i++) begin
            tick();
            checks++;
            if (bus.dma_start !== 1'b1 || bus.dma_addr !== ea
                || bus.dma_len !== el) begin
                errors++;
                $display("FAIL bp_stable: got %b %h %0d expected 1 %h %0d",
                         bus.dma_start, bus.dma_addr, bus.dma_len, ea, el);
            end
        end
        bus.dma_ready = 1'b1;
        tick();
        bus.dma_ready = 1'b0;
        checks++;
        if (bus.dma_start !== 1'b0) begin
            errors++;
            $display("FAIL start_drop: got %b expected 0", bus.dma_start);
        end
    endtask

    task automatic finish_plane(input int ddelay, input logic exp_next);
        for (int i = 0; i < ddelay - 1; i++) begin
            tick();
            checks++;
            if (bus.dma_start !== 1'b0) begin
                errors++;
                $display("FAIL one_accept: got %b expected 0", bus.dma_start);
            end
        end
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        checks++;
        if (bus.dma_start !== exp_next) begin
            errors++;
            $display("FAIL next_issue: got %b expected %b",
                     bus.dma_start, exp_next);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.dma_start, bus.dma_abort, bus.irq, bus.yuv_ctrl} !== 7'd0
            || bus.dma_addr !== 32'd0 || bus.dma_len !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b %h %0d expected zeros",
                     {bus.dma_start, bus.dma_abort, bus.irq, bus.yuv_ctrl},
                     bus.dma_addr, bus.dma_len);
        end
        reset_n = 1'b1;
        tick();
        rd(3'd1, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_status: got %h expected 0", d);
        end
        rd(3'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected 0", d);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        wr(3'd2, 32'd64);
        wr(3'd3, 32'd32);
        wr(3'd4, 32'h1000);
        wr(3'd5, 32'hFFFF);
        rd(3'd5, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reg5_read: got %h expected 0", d);
        end
        rd(3'd4, d);
        checks++;
        if (d !== 32'h1000) begin
            errors++;
            $display("FAIL base_read: got %h expected 1000", d);
        end
        wr(3'd0, 32'h1);
        checks++;
        if (bus.yuv_ctrl[3] !== 1'b1 || bus.dma_start !== 1'b0) begin
            errors++;
            $display("FAIL load_cycle: got busy=%b start=%b expected 1 0",
                     bus.yuv_ctrl[3], bus.dma_start);
        end
        rd(3'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL start_reads0: got %h expected 0", d);
        end
        tick();
        checks++;
        if (bus.dma_start !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: got %b expected 1", bus.dma_start);
        end
        accept_plane(32'h1000, 24'd2048, 2'd0, 0);
        finish_plane(5, 1'b1);
        accept_plane(32'h1800, 24'd512, 2'd1, 0);
        finish_plane(5, 1'b1);
        accept_plane(32'h1A00, 24'd512, 2'd2, 0);
        finish_plane(5, 1'b0);
        rd(3'd1, d);
        checks++;
        if (d !== 32'h0001_000C) begin
            errors++;
            $display("FAIL frame_status: got %h expected 0001000c", d);
        end
        wr(3'd1, 32'h8);
        rd(3'd1, d);
        checks++;
        if (d !== 32'h0001_0004) begin
            errors++;
            $display("FAIL done_w1c: got %h expected 00010004", d);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        wr(3'd2, 32'd16);
        wr(3'd3, 32'd16);
        wr(3'd4, 32'h2000);
        wr(3'd0, 32'h1);
        accept_plane(32'h2000, 24'd256, 2'd0, 10);
        finish_plane(5, 1'b1);
        accept_plane(32'h2100, 24'd64, 2'd1, 0);
        finish_plane(3, 1'b1);
        accept_plane(32'h2140, 24'd64, 2'd2, 0);
        finish_plane(3, 1'b0);
        rd(3'd1, d);
        checks++;
        if (d[31:16] !== 16'd2) begin
            errors++;
            $display("FAIL bp_frame_cnt: got %0d expected 2", d[31:16]);
        end
    endtask

    task automatic test_zero_dim();
        logic [31:0] d;
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd16);
        wr(3'd0, 32'h1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.dma_start !== 1'b0 || bus.yuv_ctrl[3] !== 1'b0) begin
                errors++;
                $display("FAIL zero_idle: got start=%b busy=%b expected 0 0",
                         bus.dma_start, bus.yuv_ctrl[3]);
            end
            tick();
        end
        rd(3'd1, d);
        checks++;
        if (d[4] !== 1'b1 || d[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_err: got %h expected err=1 busy=0", d);
        end
        wr(3'd1, 32'h10);
        rd(3'd1, d);
        checks++;
        if (d[4] !== 1'b0) begin
            errors++;
            $display("FAIL err_w1c: got %h expected err=0", d);
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        wr(3'd2, 32'd64);
        wr(3'd3, 32'd32);
        wr(3'd4, 32'h1000);
        wr(3'd1, 32'h8);
        wr(3'd0, 32'h1);
        accept_plane(32'h1000, 24'd2048, 2'd0, 0);
        finish_plane(5, 1'b1);
        accept_plane(32'h1800, 24'd512, 2'd1, 0);
        tick();
        wr(3'd0, 32'h4);
        checks++;
        if (bus.dma_abort !== 1'b1 || bus.yuv_ctrl[3] !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: got abort=%b busy=%b expected 1 0",
                     bus.dma_abort, bus.yuv_ctrl[3]);
        end
        tick();
        checks++;
        if (bus.dma_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_width: got %b expected 0", bus.dma_abort);
        end
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.dma_start !== 1'b0) begin
                errors++;
                $display("FAIL late_done: got start=%b expected 0",
                         bus.dma_start);
            end
            tick();
        end
        rd(3'd1, d);
        checks++;
        if (d !== 32'h0002_0002) begin
            errors++;
            $display("FAIL abort_status: got %h expected 00020002", d);
        end
        wr(3'd0, 32'h4);
        checks++;
        if (bus.dma_abort !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort: got %b expected 0", bus.dma_abort);
        end
        wr(3'd0, 32'h5);
        checks++;
        if (bus.yuv_ctrl[3] !== 1'b0 || bus.dma_abort !== 1'b0) begin
            errors++;
            $display("FAIL start_abort: got busy=%b abort=%b expected 0 0",
                     bus.yuv_ctrl[3], bus.dma_abort);
        end
    endtask

    task automatic test_continuous();
        logic [31:0] d;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wr(3'd2, 32'd8);
        wr(3'd3, 32'd4);
        wr(3'd4, 32'h100);
        wr(3'd0, 32'hB);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early: got %b expected 0", bus.irq);
        end
        for (int f = 0; f < 3; f++) begin
            accept_plane(32'h100, 24'd32, 2'd0, 0);
            finish_plane(2, 1'b1);
            accept_plane(32'h120, 24'd8, 2'd1, 0);
            finish_plane(2, 1'b1);
            accept_plane(32'h128, 24'd8, 2'd2, 0);
            finish_plane(2, 1'b0);
            checks++;
            if (bus.irq !== 1'b1 || bus.yuv_ctrl[2] !== (f % 2 == 0)
                || bus.yuv_ctrl[3] !== (f < 2)) begin
                errors++;
                $display("FAIL cont_frame%0d: got irq=%b ctrl=%b", f,
                         bus.irq, bus.yuv_ctrl);
            end
            if (f == 1) wr(3'd0, 32'h2);
        end
        rd(3'd1, d);
        checks++;
        if (d !== 32'h0003_000C) begin
            errors++;
            $display("FAIL cont_status: got %h expected 0003000c", d);
        end
        wr(3'd1, 32'h8);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b expected 0", bus.irq);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] d;
        wr(3'd2, 32'd64);
        wr(3'd3, 32'd32);
        wr(3'd4, 32'h1000);
        wr(3'd0, 32'h3);
        accept_plane(32'h1000, 24'd2048, 2'd0, 0);
        finish_plane(5, 1'b1);
        accept_plane(32'h1800, 24'd512, 2'd1, 0);
        finish_plane(5, 1'b1);
        reset_n = 1'b0;
        tick();
        checks++;
        if ({bus.dma_start, bus.dma_abort, bus.irq, bus.yuv_ctrl} !== 7'd0
            || bus.dma_addr !== 32'd0 || bus.dma_len !== 24'd0) begin
            errors++;
            $display("FAIL midop_reset: got %b %h %0d expected zeros",
                     {bus.dma_start, bus.dma_abort, bus.irq, bus.yuv_ctrl},
                     bus.dma_addr, bus.dma_len);
        end
        rd(3'd1, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL midop_status: got %h expected 0", d);
        end
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.dma_start !== 1'b0 || bus.dma_abort !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got start=%b abort=%b expected 0 0",
                     bus.dma_start, bus.dma_abort);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        bus.dma_ready  = 1'b0;
        bus.dma_done   = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_zero_dim();
        test_abort();
        test_continuous();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/yuv_plane_seq.md
Name: yuv_plane_seq

Overview:
- Avalon-MM-configured sequencer that moves one 4:2:0 frame as three plane transfers in order: Y, then U, then V.
- Computes each plane's length and address from the programmed width, height and base address.
- Drives a DMA-style request/done handshake per plane and exports a 4-bit plane/status word to the YUV datapath.
- Sits between the Nios control bus and the camera-to-Kvazaar frame mover.

Parameters:
- DIM_W, 12, width of FRAME_W/FRAME_H fields (max 4095 pixels per dimension).
- LEN_W, 24, width of dma_len; must be at least 2*DIM_W.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low, sampled on rising clk
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data; combinational from address, unused bits 0
- irq  out  1  interrupt = done & irq_en
- dma_start  out  1  plane transfer request; held until accepted
- dma_ready  in  1  DMA accepts request when dma_start & dma_ready
- dma_addr  out  32  plane byte address; valid while dma_start
- dma_len  out  LEN_W  plane byte count; valid while dma_start
- dma_done  in  1  one-cycle pulse; current plane finished
- dma_abort  out  1  one-cycle pulse on abort
- yuv_ctrl  out  4  {busy, frame_parity, plane[1:0]}; plane 0=Y, 1=U, 2=V

Behaviour:
- Registers; a write occurs when chipselect & ~write_n.
  - 0 CTRL: bit0 start (write 1 = pulse, reads 0); bit1 irq_en; bit2 abort (write 1 = pulse, reads 0); bit3 continuous.
  - 1 STATUS (RO except W1C bits): bit0 busy; bits[2:1] plane; bit3 done (sticky, W1C); bit4 err (sticky, W1C); bits[31:16] frame_cnt.
  - 2 FRAME_W: [DIM_W-1:0].
  - 3 FRAME_H: [DIM_W-1:0].
  - 4 BASE: [31:0].
  - 5–7: read 0, writes ignored.
- Reset (reset_n=0 at an edge) clears all of the following:
  - all registers, frame_cnt and frame_parity;
  - state goes to IDLE;
  - dma_start=0, dma_abort=0, irq=0, yuv_ctrl=0, dma_addr=0, dma_len=0.
  - Reset mid-transfer drops dma_start immediately, with no abort pulse.
- FSM: IDLE -> LOAD -> ISSUE -> WAIT -> (ISSUE next plane | IDLE/LOAD).
  - IDLE: on start, if W=0 or H=0, set err and stay in IDLE. Otherwise snapshot W, H, BASE into shadow regs and go to LOAD.
  - LOAD (1 cycle):
    - ysize = W*H, zero-extended to LEN_W;
    - csize = ysize>>2 (truncating);
    - plane = 0;
    - go to ISSUE.
  - ISSUE: dma_start=1 with the following address and length per plane:
    - Y: addr = base, len = ysize.
    - U: addr = base + ysize, len = csize.
    - V: addr = base + ysize + csize, len = csize.
    - Address arithmetic is 32-bit modulo 2^32.
    - On dma_start & dma_ready, go to WAIT; dma_start is low from the next cycle.
  - WAIT: on dma_done:
    - if plane < 2: plane++ and go to ISSUE;
    - else: set done, frame_cnt++ (wraps 0xFFFF -> 0), toggle frame_parity.
    - If continuous=1, go to LOAD, re-snapshotting the current W/H/BASE. Otherwise go to IDLE.
- Latency:
  - A start write in cycle N gives busy=1 in N+1 (LOAD) and dma_start=1 in N+2.
  - dma_done in cycle M gives the next plane's dma_start in M+1.
- busy = state != IDLE.
- Writes to W/H/BASE while busy update the registers but do not affect the frame in flight.
- Start while busy is ignored, with no err.
- Abort while busy:
  - next state is IDLE, dma_start=0 next cycle;
  - dma_abort pulses one cycle;
  - done and frame_cnt unchanged.
  - Abort while IDLE has no effect and no pulse.
  - Start and abort in the same write: abort wins, start is ignored.
- dma_done outside WAIT is ignored.
- dma_ready is only sampled in ISSUE.
- A W1C write to bit3/bit4 in the same cycle a set event occurs: the set wins.
- irq is a level signal; it clears when done is cleared or irq_en=0.

Test Plan:
- Single frame: W=64, H=32, BASE=0x1000, start; DMA ready immediately, done 5 cycles after each accept.
  - Required: (0x1000, 2048), then (0x1800, 512), then (0x1A00, 512).
  - Required: done=1, frame_cnt=1, busy=0, yuv_ctrl.plane sequence 0,1,2.
- Backpressure: dma_ready=0 for 10 cycles in Y ISSUE -> dma_start, addr and len stable for all 10 cycles; exactly one accept.
- Zero dimension: W=0, H=16, start -> err=1, busy stays 0, no dma_start.
  - Required: W1C write of 0x10 to STATUS clears err.
- Abort: abort written during U WAIT -> dma_abort pulses 1 cycle, busy=0 next cycle, frame_cnt unchanged, later dma_done ignored.
- Continuous with irq: continuous=1, irq_en=1, W=8, H=4.
  - Required: 3 frames complete with lengths 32/8/8 each and frame_cnt=3.
  - Required: irq asserts after frame 1 and remains asserted until done is cleared.
- Reset mid-operation: reset_n=0 for 1 cycle during V ISSUE -> all outputs 0 next cycle and STATUS reads 0.
